aes128_subbytes_seq: RTL
========================

AES128_SUBBYTES_SEQ -- requirements
Module: aes128_subbytes_seq

Interface
REQ-001 SHALL have parameter LATENCY, default 3, meaning the fixed pipeline depth in cycles of the external S-box datapath (front basis, inverse, back basis); legal range 1..8.
REQ-002 SHALL have port in_clock, input, 1 bit: single clock, all state updates on its rising edge.
REQ-003 SHALL have port in_reset, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL have port in_state_valid, input, 1 bit: upstream offers a 128-bit state.
REQ-005 SHALL have port out_state_ready, output, 1 bit: block accepts a state.
REQ-006 SHALL have port in_state, input, 128 bits: input state; byte i = bits [8i+7:8i].
REQ-007 SHALL have port out_sbox_byte, output, 8 bits: byte driven into the S-box datapath.
REQ-008 SHALL have port out_sbox_valid, output, 1 bit: out_sbox_byte is a live issue this cycle.
REQ-009 SHALL have port in_sbox_byte, input, 8 bits: S-box result, valid exactly LATENCY cycles after the matching issue.
REQ-010 SHALL have port out_result, output, 128 bits: substituted state; byte i = S(in_state byte i).
REQ-011 SHALL have port out_result_valid, output, 1 bit: out_result holds a complete result.
REQ-012 SHALL have port in_result_ready, input, 1 bit: downstream accepts the result.
REQ-013 SHALL have port out_busy, output, 1 bit: high in every state except IDLE.

Function
REQ-014 SHALL implement FSM states IDLE, ISSUE, DRAIN, DONE.
REQ-015 IDLE: out_state_ready=1; on in_state_valid=1, SHALL latch in_state, clear the issue counter to 0, and go to ISSUE.
REQ-016 ISSUE: out_sbox_valid=1, out_sbox_byte = latched byte[issue counter]; counter increments 0..15, one byte per cycle, ascending; after byte 15, go to DRAIN.
REQ-017 SHALL track in-flight issues with a LATENCY-deep valid shift register and a 4-bit capture counter; when the tap is 1, in_sbox_byte SHALL be written to result byte[capture counter], then the capture counter increments.
REQ-018 DRAIN: out_sbox_valid=0; on capture of byte 15, go to DONE.
REQ-019 Timing: with the accept edge as edge 0, byte k is issued in cycle k+1 and captured at edge k+1+LATENCY; out_result_valid SHALL first be high in the cycle after edge 16+LATENCY (edge 19 for LATENCY=3).
REQ-020 DONE: out_result_valid=1 and out_result stable until in_result_ready=1; on that edge, go to IDLE.
REQ-021 out_state_ready SHALL be 0 outside IDLE; in_state_valid and in_state changes outside IDLE SHALL be ignored.
REQ-022 In DONE with in_result_ready=0 indefinitely, SHALL hold all outputs unchanged (no timeout).
REQ-023 Back-to-back: minimum accept-to-accept spacing SHALL be 18+LATENCY cycles; no overlap of two states in the S-box pipeline.
REQ-024 When out_sbox_valid=0, out_sbox_byte SHALL be 0x00.
REQ-025 Issue and capture counters SHALL not wrap within one transaction; both SHALL clear to 0 on entry to ISSUE.

Reset
REQ-026 While in_reset=1 at a rising edge: state SHALL go to IDLE; counters, valid shift register, latched state and out_result SHALL clear to 0.
REQ-027 After reset: out_state_ready=1, out_sbox_valid=0, out_sbox_byte=0x00, out_result_valid=0, out_result=0, out_busy=0.
REQ-028 Reset mid-ISSUE or mid-DRAIN SHALL abandon the transaction; in_sbox_byte values arriving after reset for abandoned issues SHALL NOT be captured.

Verification
REQ-029 All-zero state, LATENCY=3, golden S-box model -> out_result = 0x63 repeated 16 times; first out_result_valid after edge 19.
REQ-030 FIPS-197 input 0x00112233445566778899aabbccddeeff -> each byte equals S(byte), e.g. byte 0x00->0x63, 0x11->0x82, 0xff->0x16; issue order byte0..byte15 checked on out_sbox_byte.
REQ-031 in_result_ready held 0 for 50 cycles in DONE -> out_result and out_result_valid constant; in_state_valid=1 during this time is not accepted.
REQ-032 in_reset=1 asserted at issue cycle 7, then a new state 0x53 repeated 16 times -> result 0xED repeated 16 times; no stale bytes.
REQ-033 Two states offered back-to-back with in_result_ready tied 1 -> accepts exactly 18+LATENCY cycles apart; both results correct.
REQ-034 Sweep LATENCY in {1, 3, 8} -> out_result_valid timing per REQ-019 and correct results.

Source files
------------

// File: rtl/aes128_subbytes_seq.sv
// aes128_subbytes_seq
// Runs the AES SubBytes step on a 128-bit state one byte at a time. The
// S-box itself is an external datapath with a fixed pipeline depth.
//
// Ports
//   in_clock          clock, all state updates on the rising edge
//   in_reset          synchronous active-high reset
//   in_state_valid    upstream offers a state
//   out_state_ready   block can accept a state (IDLE only)
//   in_state          state to substitute, byte i = bits [8i+7:8i]
//   out_sbox_byte     byte issued to the S-box datapath (0x00 when idle)
//   out_sbox_valid    out_sbox_byte is a live issue this cycle
//   in_sbox_byte      S-box result, LATENCY cycles after its issue
//   out_result        substituted state
//   out_result_valid  out_result is complete
//   in_result_ready   downstream takes the result
//   out_busy          high whenever the FSM is not in IDLE
//
// state | meaning
// IDLE  | waiting for a state, out_state_ready high
// ISSUE | driving one latched byte per cycle into the S-box, byte 0 first
// DRAIN | all bytes issued, waiting for the last S-box result
// DONE  | out_result complete and held until in_result_ready

module aes128_subbytes_seq #(
  parameter int LATENCY = 3
) (
  input  logic         in_clock,
  input  logic         in_reset,
  input  logic         in_state_valid,
  output logic         out_state_ready,
  input  logic [127:0] in_state,
  output logic [7:0]   out_sbox_byte,
  output logic         out_sbox_valid,
  input  logic [7:0]   in_sbox_byte,
  output logic [127:0] out_result,
  output logic         out_result_valid,
  input  logic         in_result_ready,
  output logic         out_busy
);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_e;

  state_e             state_q, state_d;
  logic [127:0]       latch_q, latch_d;
  logic [127:0]       result_q, result_d;
  logic [3:0]         issue_cnt_q, issue_cnt_d;
  logic [3:0]         cap_cnt_q, cap_cnt_d;
  logic [LATENCY-1:0] vld_q, vld_d;
  logic               tap;

  // The valid shift register mirrors the external pipeline, so its last
  // stage marks exactly the cycles where in_sbox_byte belongs to us.
  // Clearing it on reset is what keeps results of abandoned issues out.
  assign tap        = vld_q[LATENCY-1];
  assign out_result = result_q;

  always_comb begin
    state_d          = state_q;
    latch_d          = latch_q;
    result_d         = result_q;
    issue_cnt_d      = issue_cnt_q;
    cap_cnt_d        = cap_cnt_q;
    out_state_ready  = 1'b0;
    out_sbox_valid   = 1'b0;
    out_sbox_byte    = 8'h00;
    out_result_valid = 1'b0;
    out_busy         = (state_q != IDLE);

    if (tap) begin
      result_d[{cap_cnt_q, 3'b000} +: 8] = in_sbox_byte;
      if (cap_cnt_q != 4'hf) begin
        cap_cnt_d = cap_cnt_q + 4'd1;
      end
    end

    case (state_q)
      IDLE: begin
        out_state_ready = 1'b1;
        if (in_state_valid) begin
          latch_d     = in_state;
          issue_cnt_d = 4'd0;
          cap_cnt_d   = 4'd0;
          state_d     = ISSUE;
        end
      end
      ISSUE: begin
        out_sbox_valid = 1'b1;
        out_sbox_byte  = latch_q[{issue_cnt_q, 3'b000} +: 8];
        if (issue_cnt_q == 4'hf) begin
          state_d = DRAIN;
        end else begin
          issue_cnt_d = issue_cnt_q + 4'd1;
        end
      end
      DRAIN: begin
        if (tap && (cap_cnt_q == 4'hf)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        out_result_valid = 1'b1;
        if (in_result_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    vld_d[0] = out_sbox_valid;
    for (int i = 1; i < LATENCY; i++) begin
      vld_d[i] = vld_q[i-1];
    end
  end

  always_ff @(posedge in_clock) begin
    if (in_reset) begin
      state_q     <= IDLE;
      latch_q     <= '0;
      result_q    <= '0;
      issue_cnt_q <= '0;
      cap_cnt_q   <= '0;
      vld_q       <= '0;
    end else begin
      state_q     <= state_d;
      latch_q     <= latch_d;
      result_q    <= result_d;
      issue_cnt_q <= issue_cnt_d;
      cap_cnt_q   <= cap_cnt_d;
      vld_q       <= vld_d;
    end
  end

endmodule
